load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The unit connects through the slave modport. The core/memory environment uses the master modport.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access.
// It does alignment checking, byte-lane steering, load extension, and an ack timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    load_store_unit_if.slave     bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [29:0] r_word;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [7:0]  w_cnt_next;
    logic        w_access;
    logic        w_resp;

    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_access   = (r_state == S_ACCESS);
    assign w_resp     = (r_state == S_RESP);

    // Decode the request as it arrives, so that it is captured already steered to its lanes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (bus.req_funct3)
            3'b000, 3'b100: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                w_legal = !bus.req_addr[0];
                w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            3'b010: begin
                w_legal = (bus.req_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = bus.req_wdata;
            end
            default: w_legal = 1'b0;
        endcase
        // Unsigned variants exist only for loads.
        if (bus.req_funct3[2] && bus.req_we) w_legal = 1'b0;
    end

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_off)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state uses non-blocking assignments and resets asynchronously, so outputs drop the moment rstn falls.
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_word   <= 30'h0;
            r_be     <= 4'b0000;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_off    <= bus.req_addr[1:0];
                        r_word   <= bus.req_addr[31:2];
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_cnt    <= 8'd0;
                        r_rdata  <= 32'h0;
                        r_err    <= !w_legal;
                        r_state  <= w_legal ? S_ACCESS : S_RESP;
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_ack) begin
                        r_rdata <= r_we ? 32'h0 : w_load;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_cnt_next == TIMEOUT_CNT) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.mem_req   = w_access;
    assign bus.mem_we    = w_access && r_we;
    assign bus.mem_be    = w_access ? r_be : 4'b0000;
    assign bus.mem_wdata = w_access ? r_wdata : 32'h0;
    assign bus.mem_addr  = {r_word, 2'b00};
    assign bus.rsp_valid = w_resp;
    assign bus.rsp_err   = w_resp && r_err;
    assign bus.rsp_rdata = w_resp ? r_rdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized traffic.
// Expected results come from a behavioural reference model.
module tb_load_store_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus_a ();
    load_store_unit_if bus_t ();

    load_store_unit #(.TIMEOUT(255)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    load_store_unit #(.TIMEOUT(4))   dut_t (.clk(clk), .rstn(rstn), .bus(bus_t));

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit exp_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int s;
        s = size_of(f3);
        if (s == 0) return 1'b1;
        if (f3[2] && we) return 1'b1;
        return (int'(addr[1:0]) % s) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int s;
        s = size_of(f3);
        if (s == 1) return 4'(1 << addr[1:0]);
        if (s == 2) return 4'(3 << addr[1:0]);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        int s;
        s = size_of(f3);
        if (s == 1) return 32'(wdata[7:0]) * 32'h0101_0101;
        if (s == 2) return 32'(wdata[15:0]) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic we, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int s;
        if (we) return 32'h0;
        s = size_of(f3);
        v = rdata >> (8 * int'(addr[1:0]));
        if (s == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (s == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- one transaction on dut_a ----------------
    task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdata);
        bit          err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [70:0] got_a, want_a;
        logic [71:0] got_r, want_r;
        logic [34:0] got_e, want_e;
        err = exp_err(we, f3, addr);
        be  = exp_be(f3, addr);
        wd  = exp_wdata(f3, wdata);
        rd  = exp_rdata(we, f3, addr, rdata);

        @(negedge clk);
        n_vec++;
        if (bus_a.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, bus_a.req_ready);
        end
        bus_a.req_valid  = 1'b1;
        bus_a.req_we     = we;
        bus_a.req_funct3 = f3;
        bus_a.req_addr   = addr;
        bus_a.req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble request inputs; the unit must have registered them already.
        bus_a.req_valid  = 1'b0;
        bus_a.req_we     = 1'($urandom);
        bus_a.req_funct3 = 3'($urandom);
        bus_a.req_addr   = $urandom;
        bus_a.req_wdata  = $urandom;

        if (err) begin
            got_e  = {bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata, bus_a.mem_req};
            want_e = {1'b1, 1'b1, 32'h0, 1'b0};
            n_vec++;
            if (got_e !== want_e) begin
                n_err++;
                $display("FAIL %s err_resp {valid,err,rdata,mem_req}: got %h want %h", name, got_e, want_e);
            end
        end else begin
            for (int k = 0; k <= delay; k++) begin
                got_a  = {bus_a.mem_req, bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr,
                          bus_a.mem_wdata, bus_a.rsp_valid};
                want_a = {1'b1, we, be, addr & 32'hFFFF_FFFC, wd, 1'b0};
                n_vec++;
                if (got_a !== want_a) begin
                    n_err++;
                    $display("FAIL %s access_cycle%0d {req,we,be,addr,wdata,rsp_valid}: got %h want %h",
                             name, k, got_a, want_a);
                end
                bus_a.mem_ack   = (k == delay);
                bus_a.mem_rdata = (k == delay) ? rdata : $urandom;
                @(posedge clk);
                #1;
                bus_a.mem_ack   = 1'b0;
                bus_a.mem_rdata = $urandom;
            end
            got_r  = {bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata, bus_a.mem_req,
                      bus_a.mem_we, bus_a.mem_be, bus_a.mem_wdata};
            want_r = {1'b1, 1'b0, rd, 1'b0, 1'b0, 4'h0, 32'h0};
            n_vec++;
            if (got_r !== want_r) begin
                n_err++;
                $display("FAIL %s resp {valid,err,rdata,req,we,be,wdata}: got %h want %h", name, got_r, want_r);
            end
        end

        @(posedge clk);
        #1;
        n_vec++;
        if ({bus_a.req_ready, bus_a.rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL %s after_resp {ready,rsp_valid}: got %b want 10", name,
                     {bus_a.req_ready, bus_a.rsp_valid});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [104:0] got;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_funct3 = 3'b0;
        bus_a.req_addr  = 32'h0; bus_a.req_wdata = 32'h0;
        bus_a.mem_ack   = 1'b0; bus_a.mem_rdata = 32'h0;
        bus_t.req_valid = 1'b0; bus_t.req_we = 1'b0; bus_t.req_funct3 = 3'b0;
        bus_t.req_addr  = 32'h0; bus_t.req_wdata = 32'h0;
        bus_t.mem_ack   = 1'b0; bus_t.mem_rdata = 32'h0;
        rstn = 1'b0;
        #12;
        got = {bus_a.req_ready, bus_a.mem_req, bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr,
               bus_a.mem_wdata, bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata};
        n_vec++;
        if (got !== {1'b1, 104'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, {1'b1, 104'h0});
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        // Accepted on the very first rising edge after release.
        run_txn("first_accept_lw", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_directed();
        run_txn("lb_0x1003", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_FF00);
        run_txn("sh_0x2002", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 32'h0);
        run_txn("lw_misaligned", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0);
        run_txn("lhu_store_illegal", 1'b1, 3'b101, 32'h0000_3000, 32'h5555_5555, 0, 32'h0);
        run_txn("funct3_011", 1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 32'h0);
        run_txn("lhu_delay5", 1'b0, 3'b101, 32'h0000_4002, 32'h0, 5, 32'hBEEF_0000);
        run_txn("sb_lane1", 1'b1, 3'b000, 32'h0000_7001, 32'hFFFF_FF5A, 1, 32'h0);
        run_txn("lh_neg", 1'b0, 3'b001, 32'h0000_7000, 32'h0, 2, 32'h1234_8001);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_txn("b2b_sw", 1'b1, 3'b010, 32'h0000_8000 + 32'(4 * i), $urandom, 0, 32'h0);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic        we;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            f3   = 3'($urandom_range(0, 7));
            we   = 1'($urandom);
            addr = $urandom;
            run_txn("random", we, f3, addr, $urandom, int'($urandom_range(0, 5)), $urandom);
        end
    endtask

    task automatic test_timeout();
        logic [34:0] got;
        @(negedge clk);
        bus_t.req_valid  = 1'b1;
        bus_t.req_we     = 1'b0;
        bus_t.req_funct3 = 3'b010;
        bus_t.req_addr   = 32'h0000_5000;
        @(posedge clk);
        #1;
        bus_t.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({bus_t.mem_req, bus_t.rsp_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL timeout_wait%0d {mem_req,rsp_valid}: got %b want 10", k,
                         {bus_t.mem_req, bus_t.rsp_valid});
            end
            @(posedge clk);
            #1;
        end
        got = {bus_t.rsp_valid, bus_t.rsp_err, bus_t.rsp_rdata, bus_t.mem_req};
        n_vec++;
        if (got !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_resp {valid,err,rdata,req}: got %h want %h", got, {1'b1, 1'b1, 32'h0, 1'b0});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus_t.req_ready, bus_t.rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL timeout_ready: got %b want 10", {bus_t.req_ready, bus_t.rsp_valid});
        end
        // A stray ack while idle must not produce anything.
        bus_t.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({bus_t.rsp_valid, bus_t.mem_req, bus_t.req_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL stray_ack%0d {rsp_valid,mem_req,ready}: got %b want 001", k,
                         {bus_t.rsp_valid, bus_t.mem_req, bus_t.req_ready});
            end
        end
        bus_t.mem_ack = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [103:0] got;
        @(negedge clk);
        bus_a.req_valid  = 1'b1;
        bus_a.req_we     = 1'b1;
        bus_a.req_funct3 = 3'b010;
        bus_a.req_addr   = 32'h0000_6000;
        bus_a.req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_access mem_req: got %b want 1", bus_a.mem_req);
        end
        #2;
        rstn = 1'b0;
        bus_a.req_valid = 1'b1;
        #1;
        got = {bus_a.mem_req, bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr, bus_a.mem_wdata,
               bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata};
        n_vec++;
        if (got !== 104'h0) begin
            n_err++;
            $display("FAIL abort_async_zero: got %h want 0", got);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        bus_a.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if ({bus_a.rsp_valid, bus_a.req_ready, bus_a.mem_req} !== 3'b010) begin
                n_err++;
                $display("FAIL abort_quiet%0d {rsp_valid,ready,mem_req}: got %b want 010", k,
                         {bus_a.rsp_valid, bus_a.req_ready, bus_a.mem_req});
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bounded run: all waits in the bench are fixed-length, so this only guards against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
